serial_frame_sync: RTL

//  Consumes the serial bit stream produced by the stimulus stage (one bit per valid cycle).

---
 rtl/serial_frame_sync_pkg.sv | 17 +
 rtl/serial_frame_sync_deser.sv | 55 +++++
 rtl/serial_frame_sync.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_sync_pkg.sv
// Shared types and helpers for the serial frame synchroniser.
// The optional statistics outputs are enabled by defining SERIAL_FRAME_SYNC_STATS_EN.
package serial_frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    function automatic int frame_bits(input int data_w, input int frame_len);
        return (1 + frame_len) * data_w;
    endfunction

endpackage

// File: rtl/serial_frame_sync_deser.sv
// Serial-to-parallel shifter with payload word-boundary strobes.
// Feeds the framing FSM with the post-shift window on every valid bit.
module sfs_deser #(
    parameter int DATA_W = 8,
    parameter int POS_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_vld,
    input  logic [POS_W-1:0]  pos,
    input  logic              pay_en,
    output logic [DATA_W-1:0] nsr,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_vld,
    output logic              frame_start
);

    logic [DATA_W-1:0] sr_r;
    logic [DATA_W-1:0] byte_r;
    logic              byte_vld_r;
    logic              frame_start_r;
    logic              word_end_s;
    logic              first_word_s;

    assign nsr          = {sr_r[DATA_W-2:0], bit_in};
    assign word_end_s   = (pos >= POS_W'(DATA_W)) && ((pos % POS_W'(DATA_W)) == POS_W'(DATA_W - 1));
    assign first_word_s = (pos == POS_W'(2 * DATA_W - 1));

    // Shift register and one-cycle payload strobes; byte_out holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r          <= '0;
            byte_r        <= '0;
            byte_vld_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            byte_vld_r    <= 1'b0;
            frame_start_r <= 1'b0;
            if (bit_vld) begin
                sr_r <= nsr;
                if (pay_en && word_end_s) begin
                    byte_r        <= nsr;
                    byte_vld_r    <= 1'b1;
                    frame_start_r <= first_word_s;
                end
            end
        end
    end

    assign byte_out    = byte_r;
    assign byte_vld    = byte_vld_r;
    assign frame_start = frame_start_r;

endmodule

// File: rtl/serial_frame_sync.sv
// Frame synchroniser: hunts for the sync word, verifies alignment, flywheels, deserialises payload.
// Define SERIAL_FRAME_SYNC_STATS_EN to add the frame_cnt / err_cnt statistics outputs.
module serial_frame_sync
    import serial_frame_sync_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEFAULT),
    parameter int                FRAME_LEN = 4,
    parameter int                LOCK_CNT  = 3,
    parameter int                LOSS_CNT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_vld,
    output logic              frame_start,
    output logic              locked,
    output logic              sync_err
`ifdef SERIAL_FRAME_SYNC_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int FRAME_BITS = frame_bits(DATA_W, FRAME_LEN);
    localparam int POS_W      = $clog2(FRAME_BITS);
    localparam int GOOD_W     = $clog2(LOCK_CNT + 1);
    localparam int MISS_W     = $clog2(LOSS_CNT + 1);

    state_t            state_r, state_s;
    logic [POS_W-1:0]  pos_r, pos_s;
    logic [GOOD_W-1:0] good_cnt_r, good_cnt_s;
    logic [MISS_W-1:0] miss_cnt_r, miss_cnt_s;
    logic              locked_r, locked_s;
    logic              sync_err_r, sync_err_s;
    logic [DATA_W-1:0] nsr_s;
    logic              sync_match_s;
    logic              sync_slot_s;

    sfs_deser #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W)
    ) u_deser (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_vld     (bit_vld),
        .pos         (pos_r),
        .pay_en      (state_r == LOCKED),
        .nsr         (nsr_s),
        .byte_out    (byte_out),
        .byte_vld    (byte_vld),
        .frame_start (frame_start)
    );

    assign sync_match_s = (nsr_s == SYNC_WORD);
    assign sync_slot_s  = bit_vld && (state_r != HUNT) && (pos_r == POS_W'(DATA_W - 1));

    // State, position and alignment counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= HUNT;
            pos_r      <= '0;
            good_cnt_r <= '0;
            miss_cnt_r <= '0;
            locked_r   <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pos_r      <= pos_s;
            good_cnt_r <= good_cnt_s;
            miss_cnt_r <= miss_cnt_s;
            locked_r   <= locked_s;
            sync_err_r <= sync_err_s;
        end
    end

    // Next-state logic: sliding search in HUNT, slot checks only once aligned.
    always_comb begin
        state_s    = state_r;
        pos_s      = pos_r;
        good_cnt_s = good_cnt_r;
        miss_cnt_s = miss_cnt_r;
        locked_s   = locked_r;
        sync_err_s = 1'b0;
        if (bit_vld) begin
            if (pos_r == POS_W'(FRAME_BITS - 1)) begin
                pos_s = '0;
            end else begin
                pos_s = pos_r + POS_W'(1);
            end
            case (state_r)
                HUNT: begin
                    if (sync_match_s) begin
                        pos_s      = POS_W'(DATA_W);
                        good_cnt_s = GOOD_W'(1);
                        if (LOCK_CNT <= 1) begin
                            state_s    = LOCKED;
                            locked_s   = 1'b1;
                            miss_cnt_s = '0;
                        end else begin
                            state_s = VERIFY;
                        end
                    end else begin
                        pos_s      = '0;
                        good_cnt_s = '0;
                    end
                end
                VERIFY: begin
                    if (sync_slot_s && sync_match_s) begin
                        if (int'(good_cnt_r) + 1 >= LOCK_CNT) begin
                            state_s    = LOCKED;
                            good_cnt_s = GOOD_W'(LOCK_CNT);
                            miss_cnt_s = '0;
                            locked_s   = 1'b1;
                        end else begin
                            good_cnt_s = good_cnt_r + GOOD_W'(1);
                        end
                    end else if (sync_slot_s) begin
                        state_s    = HUNT;
                        good_cnt_s = '0;
                        pos_s      = '0;
                    end else begin
                        good_cnt_s = good_cnt_r;
                    end
                end
                LOCKED: begin
                    if (sync_slot_s && sync_match_s) begin
                        miss_cnt_s = '0;
                    end else if (sync_slot_s) begin
                        sync_err_s = 1'b1;
                        if (int'(miss_cnt_r) + 1 >= LOSS_CNT) begin
                            state_s    = HUNT;
                            locked_s   = 1'b0;
                            miss_cnt_s = MISS_W'(LOSS_CNT);
                            good_cnt_s = '0;
                            pos_s      = '0;
                        end else begin
                            miss_cnt_s = miss_cnt_r + MISS_W'(1);
                        end
                    end else begin
                        miss_cnt_s = miss_cnt_r;
                    end
                end
                default: begin
                    state_s    = HUNT;
                    pos_s      = '0;
                    good_cnt_s = '0;
                    miss_cnt_s = '0;
                    locked_s   = 1'b0;
                end
            endcase
        end else begin
            pos_s = pos_r;
        end
    end

    assign locked   = locked_r;
    assign sync_err = sync_err_r;

`ifdef SERIAL_FRAME_SYNC_STATS_EN
    logic [15:0] frame_cnt_r;
    logic [15:0] err_cnt_r;

    // Good-sync and sync-error event counters, free-running modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
            err_cnt_r   <= 16'd0;
        end else begin
            if (sync_slot_s && sync_match_s && (state_r == LOCKED)) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if (sync_err_s) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_r;
    assign err_cnt   = err_cnt_r;
`endif

endmodule
